// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition capture block: FSM encoding and FIFO word layout.
package adc_acq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } acq_state_t;

    localparam int OV_BIT  = 31;
    localparam int SUM_MSB = 30;

endpackage

// File: rtl/adc_acq_accum.sv
// Sample formatting and group accumulation: sums 2^dec_log2 samples and ORs their overrange flags.
module adc_acq_accum
    import adc_acq_pkg::*;
#(
    parameter int ADC_WIDTH    = 14,
    parameter int DEC_LOG2_MAX = 4,
    parameter int ADC_TWOS     = 1,
    localparam int ACC_W       = ADC_WIDTH + DEC_LOG2_MAX
) (
    input  logic                 SYS_CLK,
    input  logic                 RESET,
    input  logic                 clear,
    input  logic                 sample_en,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_ov,
    input  logic [2:0]           dec_log2,
    output logic                 group_done,
    output logic [ACC_W-1:0]     sum_final,
    output logic                 ov_final
);

    logic [ADC_WIDTH-1:0]    data_fmt;
    logic [ACC_W-1:0]        sample_ext;
    logic [ACC_W-1:0]        acc_q;
    logic [DEC_LOG2_MAX-1:0] idx_q;
    logic [DEC_LOG2_MAX-1:0] idx_last;
    logic                    ov_q;

    assign data_fmt   = (ADC_TWOS != 0) ? adc_data
                                        : {~adc_data[ADC_WIDTH-1], adc_data[ADC_WIDTH-2:0]};
    assign sample_ext = {{DEC_LOG2_MAX{data_fmt[ADC_WIDTH-1]}}, data_fmt};
    assign idx_last   = DEC_LOG2_MAX'((32'd1 << dec_log2) - 32'd1);

    // The completing sample is folded in combinationally so the word is ready the next cycle.
    assign group_done = sample_en && (idx_q == idx_last);
    assign sum_final  = acc_q + sample_ext;
    assign ov_final   = ov_q | adc_ov;

    always_ff @(posedge SYS_CLK) begin
        if (RESET || clear) begin
            acc_q <= '0;
            ov_q  <= 1'b0;
            idx_q <= '0;
        end else if (sample_en) begin
            if (group_done) begin
                acc_q <= '0;
                ov_q  <= 1'b0;
                idx_q <= '0;
            end else begin
                acc_q <= sum_final;
                ov_q  <= ov_final;
                idx_q <= idx_q + DEC_LOG2_MAX'(1);
            end
        end
    end

endmodule

// File: rtl/adc_acq_capture.sv
// Acquisition controller: gates the ADC driver, decimates its stream and writes summed words to the FIFO.
//   state   | meaning
//   IDLE    | waiting for start
//   CAPTURE | acq_en high, accepting samples until n_words groups complete
//   DRAIN   | ignoring late driver pulses until adc_ready is low for a cycle
module adc_acq_capture
    import adc_acq_pkg::*;
#(
    parameter int ADC_WIDTH    = 14,
    parameter int DEC_LOG2_MAX = 4,
    parameter int CNT_WIDTH    = 24,
    parameter int ADC_TWOS     = 1
) (
    input  logic                 SYS_CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [2:0]           dec_log2,
    input  logic [CNT_WIDTH-1:0] n_words,
    output logic                 acq_en,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_ov,
    input  logic                 adc_ready,
    output logic [31:0]          fifo_data,
    output logic                 fifo_wr,
    input  logic                 fifo_full,
    output logic                 busy,
    output logic                 done,
    output logic                 fifo_ovf
);

    localparam int ACC_W = ADC_WIDTH + DEC_LOG2_MAX;

    acq_state_t           state_q, state_d;
    logic [2:0]           dec_q;
    logic [2:0]           dec_clamped;
    logic [CNT_WIDTH-1:0] words_left_q;
    logic                 start_acc;
    logic                 sample_en;
    logic                 group_done;
    logic                 ov_final;
    logic                 last_word;
    logic                 done_d;
    logic [ACC_W-1:0]     sum_final;

    assign dec_clamped = (dec_log2 > 3'(DEC_LOG2_MAX)) ? 3'(DEC_LOG2_MAX) : dec_log2;
    assign start_acc   = start && (state_q == ST_IDLE);
    assign sample_en   = (state_q == ST_CAPTURE) && adc_ready;
    // Down-counter from n_words; terminal count at 1 so all-ones never wraps.
    assign last_word   = (words_left_q == CNT_WIDTH'(1));
    assign acq_en      = (state_q == ST_CAPTURE);
    assign busy        = (state_q != ST_IDLE);

    adc_acq_accum #(
        .ADC_WIDTH   (ADC_WIDTH),
        .DEC_LOG2_MAX(DEC_LOG2_MAX),
        .ADC_TWOS    (ADC_TWOS)
    ) u_accum (
        .SYS_CLK   (SYS_CLK),
        .RESET     (RESET),
        .clear     (start_acc),
        .sample_en (sample_en),
        .adc_data  (adc_data),
        .adc_ov    (adc_ov),
        .dec_log2  (dec_q),
        .group_done(group_done),
        .sum_final (sum_final),
        .ov_final  (ov_final)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:    if (start) state_d = (n_words == '0) ? ST_DRAIN : ST_CAPTURE;
            ST_CAPTURE: if (group_done && last_word) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!adc_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            dec_q        <= '0;
            words_left_q <= '0;
            fifo_data    <= '0;
            fifo_wr      <= 1'b0;
            done         <= 1'b0;
            fifo_ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            fifo_wr <= group_done && !fifo_full;
            if (group_done && !fifo_full) begin
                fifo_data[OV_BIT]    <= ov_final;
                fifo_data[SUM_MSB:0] <= {{(SUM_MSB + 1 - ACC_W){sum_final[ACC_W-1]}}, sum_final};
            end
            if (start_acc) begin
                dec_q        <= dec_clamped;
                words_left_q <= n_words;
                fifo_ovf     <= 1'b0;
            end else if (group_done) begin
                words_left_q <= words_left_q - CNT_WIDTH'(1);
                if (fifo_full) fifo_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_acq_capture.sv
// Directed and randomized bench for adc_acq_capture against a group-sum reference model.
module tb_adc_acq_capture;

    localparam int CNT_WIDTH = 24;

    logic                 SYS_CLK = 1'b0;
    logic                 RESET;
    logic                 start;
    logic [2:0]           dec_log2;
    logic [CNT_WIDTH-1:0] n_words;
    logic                 acq_en;
    logic [13:0]          adc_data;
    logic                 adc_ov;
    logic                 adc_ready;
    logic [31:0]          fifo_data;
    logic                 fifo_wr;
    logic                 fifo_full;
    logic                 busy;
    logic                 done;
    logic                 fifo_ovf;

    adc_acq_capture dut (
        .SYS_CLK  (SYS_CLK),
        .RESET    (RESET),
        .start    (start),
        .dec_log2 (dec_log2),
        .n_words  (n_words),
        .acq_en   (acq_en),
        .adc_data (adc_data),
        .adc_ov   (adc_ov),
        .adc_ready(adc_ready),
        .fifo_data(fifo_data),
        .fifo_wr  (fifo_wr),
        .fifo_full(fifo_full),
        .busy     (busy),
        .done     (done),
        .fifo_ovf (fifo_ovf)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] wr_q[$];
    int          done_cnt = 0;
    int          accept_cnt = 0;

    int samp[$];
    bit sov[$];
    bit drop[$];
    bit gap_en;
    bit mid_start;

    always @(negedge SYS_CLK) begin
        if (fifo_wr) wr_q.push_back(fifo_data);
        if (done) done_cnt++;
        if (acq_en && adc_ready) accept_cnt++;
    end

    task automatic step();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic gen_random(input int nsamp, input int ov_one_in);
        samp.delete();
        sov.delete();
        for (int i = 0; i < nsamp; i++) begin
            samp.push_back(int'($urandom_range(0, 16383)) - 8192);
            sov.push_back($urandom_range(0, ov_one_in - 1) == 0);
        end
    endtask

    task automatic run_acq(input string tag, input int dl, input int nw, input int extra);
        int          d_eff;
        int          gsz;
        int          k;
        int          sum;
        bit          ov;
        bit          exp_ovf;
        logic [31:0] exp_q[$];

        d_eff   = (dl > 4) ? 4 : dl;
        gsz     = 1 << d_eff;
        exp_ovf = 1'b0;
        k       = 0;
        for (int w = 0; w < nw; w++) begin
            sum = 0;
            ov  = 1'b0;
            for (int s = 0; s < gsz; s++) begin
                sum += samp[k];
                ov  |= sov[k];
                k++;
            end
            if (drop[w]) exp_ovf = 1'b1;
            else exp_q.push_back({ov, 31'(sum)});
        end

        wr_q.delete();
        done_cnt   = 0;
        accept_cnt = 0;
        dec_log2   = 3'(dl);
        n_words    = CNT_WIDTH'(nw);
        start      = 1'b1;
        step();
        start    = 1'b0;
        dec_log2 = 3'($urandom);
        n_words  = CNT_WIDTH'($urandom);
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " acq_en_after_start"}, 32'(acq_en), 32'(nw != 0));

        k = 0;
        for (int w = 0; w < nw; w++) begin
            for (int s = 0; s < gsz; s++) begin
                if (gap_en) begin
                    repeat ($urandom_range(0, 2)) begin
                        adc_ready = 1'b0;
                        adc_data  = 14'($urandom);
                        step();
                    end
                end
                adc_ready = 1'b1;
                adc_data  = 14'(samp[k]);
                adc_ov    = sov[k];
                fifo_full = drop[w];
                if (mid_start && k == 1) begin
                    start    = 1'b1;
                    n_words  = '0;
                    dec_log2 = 3'd0;
                end
                step();
                start = 1'b0;
                k++;
                if (s == gsz - 1) check({tag, " wr_latency"}, 32'(fifo_wr), 32'(!drop[w]));
            end
        end
        fifo_full = 1'b0;
        adc_ov    = 1'b0;
        if (nw != 0) check({tag, " acq_en_drop"}, 32'(acq_en), 32'd0);

        repeat (extra) begin
            adc_ready = 1'b1;
            adc_data  = 14'($urandom);
            step();
        end
        adc_ready = 1'b0;
        step();
        check({tag, " done_pulse"}, 32'(done), 32'd1);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        step();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);

        check({tag, " wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) check({tag, " word"}, wr_q[i], exp_q[i]);
        check({tag, " accepts"}, 32'(accept_cnt), 32'(nw * gsz));
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " fifo_ovf"}, 32'(fifo_ovf), 32'(exp_ovf));
    endtask

    initial begin
        RESET     = 1'b1;
        start     = 1'b0;
        dec_log2  = '0;
        n_words   = '0;
        adc_data  = '0;
        adc_ov    = 1'b0;
        adc_ready = 1'b0;
        fifo_full = 1'b0;
        gap_en    = 1'b0;
        mid_start = 1'b0;
        repeat (3) step();
        check("rst acq_en", 32'(acq_en), 32'd0);
        check("rst fifo_wr", 32'(fifo_wr), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst fifo_ovf", 32'(fifo_ovf), 32'd0);
        check("rst fifo_data", fifo_data, 32'd0);
        RESET = 1'b0;
        step();

        // T1: constant 100, groups of 4, continuous ready
        samp.delete(); sov.delete(); drop = '{0, 0, 0};
        repeat (12) begin samp.push_back(100); sov.push_back(1'b0); end
        run_acq("t1", 2, 3, 3);
        for (int i = 0; i < 3; i++) check("t1 const_word", wr_q[i], 32'h0000_0190);

        // T2: one sample per word, negative extremes
        samp = '{-1, -8192}; sov = '{0, 0}; drop = '{0, 0};
        run_acq("t2", 0, 2, 0);
        check("t2 word0", wr_q[0], 32'h7FFF_FFFF);
        check("t2 word1", wr_q[1], 32'h7FFF_E000);

        // T3: overrange on one sample of the second group only
        gen_random(6, 1 << 30);
        sov = '{0, 0, 1, 0, 0, 0}; drop = '{0, 0, 0};
        run_acq("t3", 1, 3, 1);
        check("t3 ov0", 32'(wr_q[0][31]), 32'd0);
        check("t3 ov1", 32'(wr_q[1][31]), 32'd1);
        check("t3 ov2", 32'(wr_q[2][31]), 32'd0);

        // T4: FIFO full during the second word
        gap_en = 1'b1;
        gen_random(12, 8);
        drop = '{0, 1, 0};
        run_acq("t4", 2, 3, 2);
        repeat (4) step();
        check("t4 ovf_sticky", 32'(fifo_ovf), 32'd1);
        gap_en = 1'b0;

        // T5: zero words, then a start pulse during capture
        samp.delete(); sov.delete(); drop.delete();
        run_acq("t5", 2, 0, 0);
        mid_start = 1'b1;
        gen_random(8, 8);
        drop = '{0, 0, 0, 0};
        run_acq("t5_mid_start", 1, 4, 1);
        mid_start = 1'b0;

        // T6: reset in the middle of a group
        wr_q.delete();
        done_cnt  = 0;
        dec_log2  = 3'd2;
        n_words   = CNT_WIDTH'(3);
        start     = 1'b1;
        step();
        start     = 1'b0;
        adc_ready = 1'b1;
        repeat (2) begin adc_data = 14'($urandom); step(); end
        RESET = 1'b1;
        step();
        check("t6 acq_en", 32'(acq_en), 32'd0);
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 fifo_data", fifo_data, 32'd0);
        RESET = 1'b0;
        repeat (5) begin adc_data = 14'($urandom); step(); end
        adc_ready = 1'b0;
        step();
        check("t6 no_wr", 32'(wr_q.size()), 32'd0);
        check("t6 no_done", 32'(done_cnt), 32'd0);
        check("t6 idle_acq_en", 32'(acq_en), 32'd0);
        gen_random(16, 8);
        drop = '{0, 0};
        run_acq("t6_restart", 3, 2, 0);

        // Randomized runs, including dec_log2 above the clamp
        for (int r = 0; r < 6; r++) begin
            int dl;
            int nw;
            int gsz;
            dl  = int'($urandom_range(0, 7));
            nw  = int'($urandom_range(1, 4));
            gsz = 1 << ((dl > 4) ? 4 : dl);
            gen_random(nw * gsz, 6);
            drop.delete();
            for (int w = 0; w < nw; w++) drop.push_back($urandom_range(0, 3) == 0);
            gap_en = $urandom_range(0, 1) == 1;
            run_acq("rand", dl, nw, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
